vga_pixel: RTL and testbench

Pixel output stage of the VGA controller, directly downstream of `vga_sync`. It holds the 512-byte video RAM, which the CPU writes through a valid/ready port, and reads the byte at `addr` from `vga_sync`. It drives registered 3-3-2 RGB together with hsync/vsync delayed to match. Outside the image window it outputs a border colour, and outside the visible area it forces black.

---
 rtl/vga_pixel.sv | 156 +++++++++++++++
 tb/tb_vga_pixel.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel.sv
// VGA pixel output stage: 512x8 video RAM with a CPU write port and a RAM clear
// engine, plus a two-stage display pipeline producing registered 3-3-2 RGB and delayed syncs.
module vga_pixel #(
  parameter logic [7:0] BORDER    = 8'h00,
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [8:0] addr,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       clr,
  output logic       clr_busy,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hsync,
  output logic       vsync
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_next;
  logic [8:0] ccnt, ccnt_next;

  logic       pend;
  logic [8:0] pend_addr;
  logic [7:0] pend_data;

  logic [7:0] mem [512];
  logic       mem_we;
  logic [8:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       commit;
  logic       accept;

  logic       act, vis;
  logic [7:0] rd_q;
  logic       act1, vis1, hs1, vs1;
  logic [7:0] pixel;

  assign act = (vcnt >= 10'd143) && (vcnt <= 10'd398) &&
               (hcnt >= 10'd400) && (hcnt <= 10'd527);
  assign vis = (vcnt >= 10'd35)  && (vcnt <= 10'd514) &&
               (hcnt >= 10'd144) && (hcnt <= 10'd783);

  assign wr_ready = !pend && (state == IDLE);
  assign clr_busy = (state == CLEAR);
  // A clear request in IDLE wins over a write offered in the same cycle.
  assign accept   = wr_valid && wr_ready && !clr;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    ccnt_next  = ccnt;
    mem_we     = 1'b0;
    mem_waddr  = pend_addr;
    mem_wdata  = pend_data;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        // A held write lands before a clear starts so it is never lost.
        if (pend && (clr || !act)) begin
          mem_we = 1'b1;
          commit = 1'b1;
        end
        if (clr) begin
          state_next = CLEAR;
          ccnt_next  = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ccnt;
        mem_wdata = CLEAR_VAL;
        ccnt_next = ccnt + 9'd1;
        if (ccnt == 9'd511) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ccnt  <= '0;
    end else begin
      state <= state_next;
      ccnt  <= ccnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (accept) begin
      pend      <= 1'b1;
      pend_addr <= wr_addr;
      pend_data <= wr_data;
    end else if (commit) begin
      pend      <= 1'b0;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block memory; a reset
  // mid-clear leaves it partially cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Stage 1: RAM read (old data on a same-address write) and window flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
      act1 <= 1'b0;
      vis1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
    end else begin
      rd_q <= mem[addr];
      act1 <= act;
      vis1 <= vis;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
    end
  end

  // Stage 2: colour select, syncs kept aligned with the colour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      pixel <= act1 ? rd_q : (vis1 ? BORDER : 8'h00);
      hsync <= hs1;
      vsync <= vs1;
    end
  end

  assign red   = pixel[7:5];
  assign green = pixel[4:2];
  assign blue  = pixel[1:0];

endmodule

// File: tb/tb_vga_pixel.sv
// Self-checking bench for vga_pixel: a spec-level model checked every cycle,
// plus directed vectors with hand-computed pixel/sync/handshake values.
module tb_vga_pixel;

  localparam logic [7:0] BORDER_C = 8'h1C;
  localparam logic [7:0] CLEAR_C  = 8'h55;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hcnt, vcnt;
  logic       hsync_in, vsync_in;
  logic [8:0] addr;
  logic       wr_valid;
  logic       wr_ready;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr;
  logic       clr_busy;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hsync, vsync;

  int n_cmp  = 0;
  int n_fail = 0;

  vga_pixel #(.BORDER(BORDER_C), .CLEAR_VAL(CLEAR_C)) dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .addr(addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .clr_busy(clr_busy),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic f_act(input logic [9:0] h, input logic [9:0] v);
    return (v >= 10'd143) && (v <= 10'd398) && (h >= 10'd400) && (h <= 10'd527);
  endfunction

  function automatic logic f_vis(input logic [9:0] h, input logic [9:0] v);
    return (v >= 10'd35) && (v <= 10'd514) && (h >= 10'd144) && (h <= 10'd783);
  endfunction

  // Behavioural model: RAM image, one held write, clear sweep, 2-deep output delay.
  logic [7:0] m_mem [512];
  bit         m_known [512];
  logic       m_pend, m_busy;
  logic [8:0] m_paddr, m_cidx;
  logic [7:0] m_pdata;
  logic [7:0] e1_pix, e2_pix;
  logic       e1_ok, e2_ok, e1_hs, e2_hs, e1_vs, e2_vs;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend <= 1'b0; m_busy <= 1'b0; m_cidx <= '0;
      m_paddr <= '0; m_pdata <= '0;
      e1_pix <= '0; e2_pix <= '0; e1_ok <= 1'b1; e2_ok <= 1'b1;
      e1_hs <= 1'b0; e2_hs <= 1'b0; e1_vs <= 1'b0; e2_vs <= 1'b0;
    end else begin
      e1_pix <= f_act(hcnt, vcnt) ? m_mem[addr] : (f_vis(hcnt, vcnt) ? BORDER_C : 8'h00);
      e1_ok  <= !f_act(hcnt, vcnt) || m_known[addr];
      e2_pix <= e1_pix; e2_ok <= e1_ok;
      e1_hs <= hsync_in; e2_hs <= e1_hs;
      e1_vs <= vsync_in; e2_vs <= e1_vs;
      if (m_busy) begin
        m_mem[m_cidx]   <= CLEAR_C;
        m_known[m_cidx] <= 1'b1;
        m_cidx <= m_cidx + 9'd1;
        if (m_cidx == 9'd511) m_busy <= 1'b0;
      end else begin
        if (m_pend && (clr || !f_act(hcnt, vcnt))) begin
          m_mem[m_paddr]   <= m_pdata;
          m_known[m_paddr] <= 1'b1;
          m_pend <= 1'b0;
        end
        if (!m_pend && wr_valid && !clr) begin
          m_pend <= 1'b1; m_paddr <= wr_addr; m_pdata <= wr_data;
        end
        if (clr) begin
          m_busy <= 1'b1; m_cidx <= '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (e2_ok) check("model_pixel", {red, green, blue}, e2_pix);
      check("model_hsync", 8'(hsync), 8'(e2_hs));
      check("model_vsync", 8'(vsync), 8'(e2_vs));
      check("model_wr_ready", 8'(wr_ready), 8'(!m_pend && !m_busy));
      check("model_clr_busy", 8'(clr_busy), 8'(m_busy));
    end
  end

  task automatic do_write(input logic [8:0] a, input logic [7:0] d);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("write_wait_ready", 8'(wr_ready), 8'h01);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_px(input logic [8:0] a, input logic [7:0] exp, input string name);
    hcnt = 10'd410; vcnt = 10'd150; addr = a;
    tick(); tick();
    check(name, {red, green, blue}, exp);
  endtask

  initial begin
    rst = 1'b0; hcnt = '0; vcnt = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    repeat (3) tick();
    check("reset_rgb", {red, green, blue}, 8'h00);
    check("reset_busy", 8'(clr_busy), 8'h00);
    rst = 1'b1;
    tick();
    check("post_reset_ready", 8'(wr_ready), 8'h01);
    check("post_reset_busy", 8'(clr_busy), 8'h00);

    // Pixel path: E3 -> 111 000 11
    do_write(9'd5, 8'hE3);
    tick();
    hcnt = 10'd410; vcnt = 10'd150; addr = 9'd5; hsync_in = 1'b1; vsync_in = 1'b0;
    tick(); tick();
    check("pix_red", 8'(red), 8'h07);
    check("pix_green", 8'(green), 8'h00);
    check("pix_blue", 8'(blue), 8'h03);
    check("pix_hsync", 8'(hsync), 8'h01);
    check("pix_vsync", 8'(vsync), 8'h00);

    // Border 1C -> 000 111 00, then blanking
    hcnt = 10'd200; vcnt = 10'd100; hsync_in = 1'b0; vsync_in = 1'b1;
    tick(); tick();
    check("border_rgb", {red, green, blue}, 8'h1C);
    check("border_green", 8'(green), 8'h07);
    check("border_hsync", 8'(hsync), 8'h00);
    check("border_vsync", 8'(vsync), 8'h01);
    hcnt = 10'd50;
    tick(); tick();
    check("blank_rgb", {red, green, blue}, 8'h00);

    // Write stall across the active span
    hcnt = 10'd420; vcnt = 10'd200; addr = 9'd5;
    do_write(9'h010, 8'hAA);
    check("stall_ready_low", 8'(wr_ready), 8'h00);
    for (int h = 421; h <= 527; h++) begin
      hcnt = 10'(h);
      tick();
    end
    check("stall_ready_end", 8'(wr_ready), 8'h00);
    hcnt = 10'd528;
    tick();
    check("stall_ready_back", 8'(wr_ready), 8'h01);
    read_px(9'h010, 8'hAA, "stall_read");

    // Full clear, with a write offered on the clr cycle and reads during the sweep
    hcnt = 10'd410; vcnt = 10'd150; addr = 9'd5;
    wr_addr = 9'd7; wr_data = 8'h99; wr_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; wr_valid = 1'b0;
    check("clear_busy_first", 8'(clr_busy), 8'h01);
    check("clear_ready_first", 8'(wr_ready), 8'h00);
    for (int k = 1; k < 512; k++) begin
      tick();
      check("clear_busy", 8'(clr_busy), 8'h01);
      check("clear_ready", 8'(wr_ready), 8'h00);
    end
    tick();
    check("clear_done_busy", 8'(clr_busy), 8'h00);
    check("clear_done_ready", 8'(wr_ready), 8'h01);
    for (int a = 0; a < 512; a++) begin
      addr = 9'(a);
      tick();
    end
    tick(); tick();
    read_px(9'd7, 8'h55, "clear_read_7");
    read_px(9'd511, 8'h55, "clear_read_511");

    // Distinct values, then a clear interrupted by reset at ccnt=100
    hcnt = '0; vcnt = '0;
    do_write(9'd50, 8'h11);
    do_write(9'd100, 8'h22);
    do_write(9'd101, 8'h33);
    do_write(9'd300, 8'h44);
    tick();
    hcnt = 10'd200; vcnt = 10'd100; hsync_in = 1'b1; vsync_in = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    check("midclr_green", 8'(green), 8'h07);
    check("midclr_hsync", 8'(hsync), 8'h01);
    rst = 1'b0;
    #1;
    check("midclr_rst_busy", 8'(clr_busy), 8'h00);
    check("midclr_rst_rgb", {red, green, blue}, 8'h00);
    check("midclr_rst_hsync", 8'(hsync), 8'h00);
    check("midclr_rst_vsync", 8'(vsync), 8'h00);
    tick(); tick();
    rst = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    check("midclr_ready", 8'(wr_ready), 8'h01);
    hcnt = '0; vcnt = '0;
    do_write(9'd200, 8'h66);
    tick();
    read_px(9'd99, 8'h55, "midclr_99");
    read_px(9'd50, 8'h55, "midclr_50");
    read_px(9'd100, 8'h22, "midclr_100");
    read_px(9'd101, 8'h33, "midclr_101");
    read_px(9'd300, 8'h44, "midclr_300");
    read_px(9'd200, 8'h66, "midclr_200");
    for (int a = 0; a < 128; a++) begin
      addr = 9'(a);
      tick();
    end
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
